led_pattern_detector: RTL and testbench
=======================================

LED_PATTERN_DETECTOR -- requirements
Module: led_pattern_detector

Interface
REQ-001 SHALL provide parameter: LOCK_N, 4, consecutive consistent transitions needed to lock (range 2..7).
REQ-002 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sample_en  in  1  one-cycle strobe; led_in valid this cycle.
- led_in  in  8  observed LED frame.
- clear  in  1  synchronous restart of detection.
- pat_id  out  3  detected pattern code (000 knight, 001 walk, 010 expand, 011 blink, 100 alternate, 101 marquee, 110 sparkle, 111 off/unknown).
- pat_locked  out  1  pat_id is trusted.
- err  out  1  one-cycle pulse; locked pattern violated.

Function
REQ-003 SHALL register led_in as prev on every accepted sample_en; a transition is the pair (prev, cur=led_in).
REQ-004 SHALL compute an 8-bit legal mask per transition, bit n set when the pair is legal for pattern n:
- knight: prev, cur adjacent in 81,42,24,18.
- walk: prev=03<<j, cur=03<<k, |j-k|=1, j,k in 0..6.
- expand: 18->3C, 3C->7E, 7E->FF, FF->7E, 7E->3C, 3C->18, 18->00, 00->18.
- blink: 00<->FF.
- alternate: AA<->55.
- marquee: cur = rotate-left(prev), prev not 00/FF.
- sparkle: cur = {prev[6:0], prev[7]^prev[5]^prev[4]^prev[3]}, prev not 00.
- off: prev=cur=00.
REQ-005 SHALL treat cur==prev with value not 00 as neutral: mask, count, outputs unchanged.
REQ-006 SHALL hold candidate mask cand[7:0] and saturating count cnt[2:0].
REQ-007 State machine, states EMPTY, HUNT, LOCKED:
- EMPTY: on sample_en store prev -> HUNT; cand=FF, cnt=0.
- HUNT, non-neutral transition: m=cand&legal; m!=0 -> cand=m, cnt+1 (saturate at LOCK_N); m==0 -> cand=legal, cnt=1 if legal!=0 else 0.
- HUNT -> LOCKED when cand is one-hot and cnt>=LOCK_N after update.
- LOCKED: legal bit of pat_id set -> stay; cleared -> err=1 one cycle, -> HUNT with cand=legal, cnt as above.
REQ-008 pat_id SHALL equal index of the one-hot cand bit in LOCKED and 111 in EMPTY/HUNT; pat_locked=1 only in LOCKED.
REQ-009 Outputs SHALL be registered, updating on the clk edge after the sample_en cycle (latency 1).
REQ-010 clear SHALL force EMPTY, pat_id=111, pat_locked=0, err=0 next edge; clear with sample_en SHALL discard the sample.
REQ-011 sample_en low SHALL hold all state; err SHALL never remain high two cycles.
REQ-012 Ambiguous pairs (e.g. 18->00 legal for expand only; FF->00 legal for blink only) SHALL be resolved solely by mask intersection, never by priority.

Reset
REQ-013 rst_n low SHALL asynchronously set EMPTY, prev=00, cand=FF, cnt=0, pat_id=111, pat_locked=0, err=0.
REQ-014 Reset mid-stream SHALL discard history; first post-reset sample only loads prev.

Structure
REQ-015 Pattern codes, knight/walk/expand tables and LFSR tap positions SHALL reside in shared package led_pattern_pkg.
REQ-016 Legal-mask computation SHALL be sub-module led_transition_classifier (combinational, prev/cur in, mask out); FSM and counters in top.

Verification
REQ-017 Bench SHALL cover:
- Knight 81,42,24,18,18,24,42 -> pat_locked=1, pat_id=000 after 4th non-neutral transition; 18,18 neutral.
- Alternate AA,55 repeated 6 frames -> lock pat_id=100; then inject 0F -> err pulse one cycle, pat_locked=0.
- Expand 18,3C,7E,FF,7E -> pat_id=010 (FF->7E excludes blink); blink 00,FF,00,FF,00 -> pat_id=011.
- Sparkle seed AA, 6 LFSR steps -> pat_id=110; marquee 07,0E,1C,38,70 -> pat_id=101.
- clear asserted with sample_en while LOCKED -> next cycle pat_id=111, pat_locked=0, sample ignored.
- rst_n low mid-hunt -> asynchronous return to reset values; 5 zero frames after release -> pat_id=111, pat_locked=1.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared pattern codes, transition tables and LFSR taps for the LED pattern detector.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    PAT_KNIGHT  = 3'd0,
    PAT_WALK    = 3'd1,
    PAT_EXPAND  = 3'd2,
    PAT_BLINK   = 3'd3,
    PAT_ALT     = 3'd4,
    PAT_MARQUEE = 3'd5,
    PAT_SPARKLE = 3'd6,
    PAT_OFF     = 3'd7
  } pat_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } det_state_e;

  // Knight sweep order; index 0 is the outermost frame.
  localparam logic [3:0][7:0] KNIGHT_TBL = {8'h18, 8'h24, 8'h42, 8'h81};

  localparam logic [7:0] WALK_BASE = 8'h03;
  localparam int         WALK_MAX  = 6;

  // Legal expand transitions as {prev, cur}.
  localparam logic [7:0][15:0] EXPAND_TBL = {
    16'h0018, 16'h1800, 16'h3C18, 16'h7E3C,
    16'hFF7E, 16'h7EFF, 16'h3C7E, 16'h183C
  };

  // Sparkle feedback taps: bits 7, 5, 4, 3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

endpackage

// File: rtl/led_transition_classifier.sv
// Combinational legality mask of one (prev, cur) frame pair, one bit per pattern code.
module led_transition_classifier
  import led_pattern_pkg::*;
(
  input  logic [7:0] prev,
  input  logic [7:0] cur,
  output logic [7:0] legal
);

  logic [7:0] rotl;
  logic [7:0] lfsr_nxt;
  logic       rot_ok;

  assign rotl     = {prev[6:0], prev[7]};
  assign lfsr_nxt = {prev[6:0], ^(prev & LFSR_TAPS)};
  // Rotating AA/55 looks exactly like alternation, and 00/FF rotate onto themselves,
  // so those frames carry no marquee evidence.
  assign rot_ok   = (prev != 8'h00) && (prev != 8'hFF) && (prev != 8'hAA) && (prev != 8'h55);

  always_comb begin
    legal = '0;
    for (int i = 0; i < 3; i++)
      if ((prev == KNIGHT_TBL[i]   && cur == KNIGHT_TBL[i+1]) ||
          (prev == KNIGHT_TBL[i+1] && cur == KNIGHT_TBL[i]))
        legal[PAT_KNIGHT] = 1'b1;
    for (int j = 0; j < WALK_MAX; j++)
      if ((prev == (WALK_BASE << j)     && cur == (WALK_BASE << (j + 1))) ||
          (prev == (WALK_BASE << (j + 1)) && cur == (WALK_BASE << j)))
        legal[PAT_WALK] = 1'b1;
    for (int k = 0; k < 8; k++)
      if ({prev, cur} == EXPAND_TBL[k])
        legal[PAT_EXPAND] = 1'b1;
    legal[PAT_BLINK]   = (prev == 8'h00 && cur == 8'hFF) || (prev == 8'hFF && cur == 8'h00);
    legal[PAT_ALT]     = (prev == 8'hAA && cur == 8'h55) || (prev == 8'h55 && cur == 8'hAA);
    legal[PAT_MARQUEE] = rot_ok && (cur == rotl);
    legal[PAT_SPARKLE] = (prev != 8'h00) && (cur == lfsr_nxt);
    legal[PAT_OFF]     = (prev == 8'h00) && (cur == 8'h00);
  end

endmodule

// File: rtl/led_pattern_detector.sv
// Narrows the set of patterns consistent with successive LED frames and locks once one remains.
module led_pattern_detector
  import led_pattern_pkg::*;
#(
  parameter int LOCK_N = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en,
  input  logic [7:0] led_in,
  input  logic       clear,
  output logic [2:0] pat_id,
  output logic       pat_locked,
  output logic       err
);

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_N);

  det_state_e state_q, state_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] cand_q, cand_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] pat_id_q, pat_id_d;
  logic       pat_locked_q, pat_locked_d;
  logic       err_q, err_d;

  logic [7:0] legal;
  logic [7:0] hit;
  logic       neutral;
  logic       one_hot;

  led_transition_classifier u_cls (
    .prev  (prev_q),
    .cur   (led_in),
    .legal (legal)
  );

  assign neutral = (led_in == prev_q) && (led_in != 8'h00);
  assign hit     = cand_q & legal;
  assign one_hot = (cand_d != 8'h00) && ((cand_d & (cand_d - 8'd1)) == 8'h00);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ST_EMPTY;
      cand_d  = 8'hFF;
      cnt_d   = '0;
    end else if (sample_en) begin
      prev_d = led_in;
      case (state_q)
        ST_EMPTY: begin
          state_d = ST_HUNT;
          cand_d  = 8'hFF;
          cnt_d   = '0;
        end
        ST_HUNT: if (!neutral) begin
          if (hit != 8'h00) begin
            cand_d = hit;
            cnt_d  = (cnt_q >= LOCK_CNT) ? LOCK_CNT : cnt_q + 3'd1;
          end else begin
            cand_d = legal;
            cnt_d  = (legal != 8'h00) ? 3'd1 : 3'd0;
          end
          if (one_hot && cnt_d >= LOCK_CNT) state_d = ST_LOCKED;
        end
        ST_LOCKED: if (!neutral && !legal[pat_id_q]) begin
          err_d   = 1'b1;
          state_d = ST_HUNT;
          cand_d  = legal;
          cnt_d   = (legal != 8'h00) ? 3'd1 : 3'd0;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    pat_locked_d = (state_d == ST_LOCKED);
    pat_id_d     = pat_locked_d ? onehot_idx(cand_d) : PAT_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      prev_q       <= 8'h00;
      cand_q       <= 8'hFF;
      cnt_q        <= '0;
      pat_id_q     <= PAT_OFF;
      pat_locked_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      pat_id_q     <= pat_id_d;
      pat_locked_q <= pat_locked_d;
      err_q        <= err_d;
    end
  end

  assign pat_id     = pat_id_q;
  assign pat_locked = pat_locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_led_pattern_detector.sv
// Directed and randomized checks of led_pattern_detector against a frame-rule reference model.
module tb_led_pattern_detector;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [2:0] pat_id;
  logic       pat_locked;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 empty, 1 hunting, 2 locked.
  int m_st, m_prev, m_cand, m_cnt, m_pid, m_lock, m_err;

  led_pattern_detector #(.LOCK_N(LOCK_N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .led_in     (led_in),
    .clear      (clear),
    .pat_id     (pat_id),
    .pat_locked (pat_locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic int ref_lfsr(input int p);
    int fb;
    fb = ((p >> 7) ^ (p >> 5) ^ (p >> 4) ^ (p >> 3)) & 1;
    return ((p << 1) & 255) | fb;
  endfunction

  function automatic int pos_in(input int v, input int tbl[5], input int n);
    for (int i = 0; i < n; i++)
      if (tbl[i] == v) return i;
    return -10;
  endfunction

  function automatic int ref_legal(input int p, input int c);
    int kn[5] = '{'h81, 'h42, 'h24, 'h18, -1};
    int ex[5] = '{'h00, 'h18, 'h3C, 'h7E, 'hFF};
    int m, d;
    m = 0;
    d = pos_in(p, kn, 4) - pos_in(c, kn, 4);
    if (d == 1 || d == -1) m |= 1;
    for (int j = 0; j <= 6; j++)
      for (int k = 0; k <= 6; k++)
        if (p == (3 << j) && c == (3 << k) && (j - k == 1 || k - j == 1)) m |= 2;
    d = pos_in(p, ex, 5) - pos_in(c, ex, 5);
    if (d == 1 || d == -1) m |= 4;
    if ((p == 0 && c == 255) || (p == 255 && c == 0)) m |= 8;
    if ((p == 'hAA && c == 'h55) || (p == 'h55 && c == 'hAA)) m |= 16;
    if (p != 0 && p != 255 && p != 'hAA && p != 'h55 && c == (((p << 1) | (p >> 7)) & 255)) m |= 32;
    if (p != 0 && c == ref_lfsr(p)) m |= 64;
    if (p == 0 && c == 0) m |= 128;
    return m;
  endfunction

  task automatic model_reset();
    m_st = 0; m_prev = 0; m_cand = 255; m_cnt = 0; m_pid = 7; m_lock = 0; m_err = 0;
  endtask

  task automatic model_step(input logic se, input int d, input logic clr);
    int lg;
    bit neutral;
    m_err = 0;
    if (clr) begin
      m_st = 0; m_cand = 255; m_cnt = 0;
    end else if (se) begin
      lg = ref_legal(m_prev, d);
      neutral = (d == m_prev) && (d != 0);
      if (m_st == 0) begin
        m_st = 1; m_cand = 255; m_cnt = 0;
      end else if (m_st == 1 && !neutral) begin
        if ((m_cand & lg) != 0) begin
          m_cand = m_cand & lg;
          m_cnt = (m_cnt + 1 > LOCK_N) ? LOCK_N : m_cnt + 1;
        end else begin
          m_cand = lg;
          m_cnt = (lg != 0) ? 1 : 0;
        end
        if ($countones(m_cand) == 1 && m_cnt >= LOCK_N) m_st = 2;
      end else if (m_st == 2 && !neutral && ((lg >> m_pid) & 1) == 0) begin
        m_err = 1; m_st = 1; m_cand = lg;
        m_cnt = (lg != 0) ? 1 : 0;
      end
      m_prev = d;
    end
    m_lock = (m_st == 2) ? 1 : 0;
    m_pid = 7;
    if (m_st == 2)
      for (int i = 0; i < 8; i++)
        if ((m_cand >> i) & 1) m_pid = i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic se, input logic [7:0] d, input logic clr);
    @(negedge clk);
    sample_en = se; led_in = d; clear = clr;
    model_step(se, int'(d), clr);
    @(posedge clk);
    #1;
    chk("pat_id", 32'(pat_id), m_pid);
    chk("pat_locked", 32'(pat_locked), m_lock);
    chk("err", 32'(err), m_err);
    sample_en = 1'b0; clear = 1'b0;
  endtask

  task automatic play(input logic [7:0] s[$]);
    foreach (s[i]) step(1'b1, s[i], 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] nxt;
    logic [7:0] last;
    int gen;
    logic se, clr;

    model_reset();
    #12;
    chk("reset_pat_id", 32'(pat_id), 7);
    chk("reset_locked", 32'(pat_locked), 0);
    chk("reset_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    play('{8'h81, 8'h42, 8'h24, 8'h18, 8'h18});
    chk("knight_neutral_unlocked", 32'(pat_locked), 0);
    step(1'b1, 8'h24, 1'b0);
    chk("knight_locked", 32'(pat_locked), 1);
    chk("knight_id", 32'(pat_id), 0);
    step(1'b1, 8'h42, 1'b0);

    step(1'b0, 8'h00, 1'b1);
    play('{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55});
    chk("alt_id", 32'(pat_id), 4);
    chk("alt_locked", 32'(pat_locked), 1);
    step(1'b1, 8'h0F, 1'b0);
    chk("alt_err_pulse", 32'(err), 1);
    chk("alt_unlocked", 32'(pat_locked), 0);
    step(1'b0, 8'h00, 1'b0);
    chk("alt_err_drop", 32'(err), 0);

    step(1'b0, 8'h00, 1'b1);
    play('{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h7E});
    chk("expand_id", 32'(pat_id), 2);
    step(1'b0, 8'h00, 1'b1);
    play('{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00});
    chk("blink_id", 32'(pat_id), 3);

    step(1'b0, 8'h00, 1'b1);
    v = 8'hAA;
    step(1'b1, v, 1'b0);
    for (int i = 0; i < 6; i++) begin
      v = 8'(ref_lfsr(int'(v)));
      step(1'b1, v, 1'b0);
    end
    chk("sparkle_id", 32'(pat_id), 6);

    step(1'b0, 8'h00, 1'b1);
    play('{8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70});
    chk("marquee_id", 32'(pat_id), 5);
    chk("marquee_locked", 32'(pat_locked), 1);

    step(1'b1, 8'hE0, 1'b1);
    chk("clear_id", 32'(pat_id), 7);
    chk("clear_locked", 32'(pat_locked), 0);
    step(1'b1, 8'hC1, 1'b0);
    chk("clear_then_load", 32'(pat_locked), 0);

    step(1'b0, 8'h00, 1'b1);
    play('{8'h00, 8'h00, 8'h00, 8'h00});
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_id", 32'(pat_id), 7);
    chk("async_rst_locked", 32'(pat_locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    play('{8'h00, 8'h00, 8'h00, 8'h00});
    chk("post_rst_4_zero", 32'(pat_locked), 0);
    step(1'b1, 8'h00, 1'b0);
    chk("post_rst_off_id", 32'(pat_id), 7);
    chk("post_rst_off_locked", 32'(pat_locked), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_locked_drop", 32'(pat_locked), 0);
    @(negedge clk);
    rst_n = 1'b1;

    gen = 0; last = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (n % 16 == 0) begin
        gen = $urandom_range(0, 4);
        case (gen)
          3: last = 8'hAA;
          4: last = 8'h00;
          default: last = 8'($urandom) | 8'h01;
        endcase
      end
      case (gen)
        0: nxt = 8'($urandom);
        1: nxt = {last[6:0], last[7]};
        2: nxt = 8'(ref_lfsr(int'(last)));
        default: nxt = ~last;
      endcase
      se  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 49) == 0);
      step(se, nxt, clr);
      if (se) last = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
